// File: rtl/proc_io_ctrl_if.sv
// ---------------------------------------------------------------------------
// proc_io_ctrl_if
// Bundles every non-clock, non-reset signal of proc_io_ctrl.
//   Control  : en, clr (in)            state, underrun, overrun, multi_en (out)
//   Upstream : s_data, s_valid (in)    s_ready (out)
//   Processor: proc_req_in, proc_out, proc_out_en (in)
//              proc_rst, proc_in (out)
//   Downstream: m_ready (in)           m_data, m_chan, m_valid (out)
// The slave modport is the controller's view; master is the environment's.
// ---------------------------------------------------------------------------
interface proc_io_ctrl_if #(
  parameter int NUBITS = 32,
  parameter int NOUT   = 7,
  parameter int NBCH   = 3
);
  logic              en;
  logic              clr;
  logic [NUBITS-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              proc_rst;
  logic [NUBITS-1:0] proc_in;
  logic              proc_req_in;
  logic [NUBITS-1:0] proc_out;
  logic [NOUT-1:0]   proc_out_en;
  logic [NUBITS-1:0] m_data;
  logic [NBCH-1:0]   m_chan;
  logic              m_valid;
  logic              m_ready;
  logic [1:0]        state;
  logic              underrun;
  logic              overrun;
  logic              multi_en;

  modport slave (
    input  en, clr, s_data, s_valid, proc_req_in, proc_out, proc_out_en, m_ready,
    output s_ready, proc_rst, proc_in, m_data, m_chan, m_valid,
           state, underrun, overrun, multi_en
  );

  modport master (
    output en, clr, s_data, s_valid, proc_req_in, proc_out, proc_out_en, m_ready,
    input  s_ready, proc_rst, proc_in, m_data, m_chan, m_valid,
           state, underrun, overrun, multi_en
  );
endinterface

// File: rtl/proc_io_ctrl.sv
// ---------------------------------------------------------------------------
// proc_io_ctrl
// Sequencing and I/O controller in front of a processor filter bank.
// Buffers upstream samples in a show-ahead input FIFO served on proc_req_in,
// collects decoded proc_out_en writes into a channel-tagged output FIFO with
// valid/ready, and holds the processor in reset until FILL samples are primed
// (and again after an underrun).
//   clk    : single clock
//   rst    : synchronous active-high reset
//   io_bus : proc_io_ctrl_if.slave (control, upstream, processor, downstream)
// ---------------------------------------------------------------------------
module proc_io_ctrl #(
  parameter int NUBITS = 32,
  parameter int IDEPTH = 16,
  parameter int ODEPTH = 8,
  parameter int NOUT   = 7,
  parameter int NBCH   = 3,
  parameter int FILL   = 8
) (
  input  logic           clk,
  input  logic           rst,
  proc_io_ctrl_if.slave  io_bus
);

  localparam int IPW   = $clog2(IDEPTH);
  localparam int IBITS = IPW + 1;
  localparam int OPW   = $clog2(ODEPTH);
  localparam int OBITS = OPW + 1;
  localparam int OW    = NBCH + NUBITS;

  localparam logic [IBITS-1:0] C_IDEPTH = IBITS'(IDEPTH);
  localparam logic [IBITS-1:0] C_FILL   = IBITS'(FILL);
  localparam logic [OBITS-1:0] C_ODEPTH = OBITS'(ODEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic [1:0]        r_state;
  logic              r_proc_rst;
  logic [NUBITS-1:0] r_imem [IDEPTH];
  logic [IPW-1:0]    r_iwr;
  logic [IPW-1:0]    r_ird;
  logic [IBITS-1:0]  r_icnt;
  logic [OW-1:0]     r_omem [ODEPTH];
  logic [OPW-1:0]    r_owr;
  logic [OPW-1:0]    r_ord;
  logic [OBITS-1:0]  r_ocnt;
  logic              r_underrun;
  logic              r_overrun;
  logic              r_multi;

  logic              w_iempty;
  logic              w_ipush;
  logic              w_req_run;
  logic              w_ipop;
  logic              w_under;
  logic              w_ofull;
  logic              w_owr_req;
  logic              w_owr;
  logic              w_oover;
  logic              w_opop;
  logic              w_multi;
  logic [NBCH-1:0]   w_chan;
  logic [1:0]        w_next_state;
  logic [OW-1:0]     w_ohead;

  // s_ready comes from the registered count only, so a full FIFO refuses a
  // push even when a pop happens in the same cycle.
  assign w_iempty  = (r_icnt == '0);
  assign w_ipush   = io_bus.s_valid & (r_icnt < C_IDEPTH);
  assign w_req_run = io_bus.proc_req_in & (r_state == S_RUN);
  assign w_ipop    = w_req_run & ~w_iempty;
  // No push-to-pop bypass: a request on an empty FIFO is an underrun even if
  // a word is being pushed on the same edge.
  assign w_under   = w_req_run & w_iempty;

  assign w_ofull   = (r_ocnt == C_ODEPTH);
  assign w_owr_req = |io_bus.proc_out_en;
  assign w_owr     = w_owr_req & ~w_ofull;
  assign w_oover   = w_owr_req & w_ofull;
  assign w_opop    = (r_ocnt != '0) & io_bus.m_ready;
  assign w_multi   = |(io_bus.proc_out_en & (io_bus.proc_out_en - NOUT'(1)));

  // Lowest set bit wins: scan from the top so the last match is the lowest.
  always_comb begin
    w_chan = '0;
    for (int k = NOUT - 1; k >= 0; k--) begin
      if (io_bus.proc_out_en[k]) w_chan = NBCH'(k);
    end
  end

  // clr and en=0 dominate every other transition; HALT only leaves through them.
  always_comb begin
    w_next_state = r_state;
    if (io_bus.clr || !io_bus.en) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_next_state = S_FILL;
        S_FILL:  if (r_icnt >= C_FILL) w_next_state = S_RUN;
        S_RUN:   if (w_under) w_next_state = S_HALT;
        S_HALT:  w_next_state = S_HALT;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // proc_rst is decoded from the next state so it changes on the same edge
  // as the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_proc_rst <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_proc_rst <= (w_next_state != S_RUN);
    end
  end

  // Storage arrays carry no reset; emptiness is tracked by the counters.
  always_ff @(posedge clk) begin
    if (w_ipush) r_imem[r_iwr] <= io_bus.s_data;
    if (w_owr)   r_omem[r_owr] <= {w_chan, io_bus.proc_out};
  end

  // clr empties both FIFOs and the sticky flags exactly like rst; any
  // transfer attempted on that edge is discarded.
  always_ff @(posedge clk) begin
    if (rst || io_bus.clr) begin
      r_iwr      <= '0;
      r_ird      <= '0;
      r_icnt     <= '0;
      r_owr      <= '0;
      r_ord      <= '0;
      r_ocnt     <= '0;
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
      r_multi    <= 1'b0;
    end else begin
      if (w_ipush) r_iwr <= r_iwr + IPW'(1);
      if (w_ipop)  r_ird <= r_ird + IPW'(1);
      r_icnt <= r_icnt + IBITS'(w_ipush) - IBITS'(w_ipop);
      if (w_owr)   r_owr <= r_owr + OPW'(1);
      if (w_opop)  r_ord <= r_ord + OPW'(1);
      r_ocnt <= r_ocnt + OBITS'(w_owr) - OBITS'(w_opop);
      if (w_under) r_underrun <= 1'b1;
      if (w_oover) r_overrun  <= 1'b1;
      if (w_multi) r_multi    <= 1'b1;
    end
  end

  // Heads read as zero when their FIFO is empty.
  assign w_ohead = (r_ocnt != '0) ? r_omem[r_ord] : '0;

  assign io_bus.s_ready  = (r_icnt < C_IDEPTH);
  assign io_bus.proc_in  = w_iempty ? '0 : r_imem[r_ird];
  assign io_bus.proc_rst = r_proc_rst;
  assign io_bus.m_valid  = (r_ocnt != '0);
  assign io_bus.m_data   = w_ohead[NUBITS-1:0];
  assign io_bus.m_chan   = w_ohead[OW-1:NUBITS];
  assign io_bus.state    = r_state;
  assign io_bus.underrun = r_underrun;
  assign io_bus.overrun  = r_overrun;
  assign io_bus.multi_en = r_multi;

endmodule
